// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - handshake, control and debug signals of the elastic stage chain
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic [DEPTH-1:0] flush_mask;
    logic [OCC_W-1:0] occupancy;
    logic [DEPTH-1:0] stage_valid;

    modport master (
        output in_valid, in_data, out_ready, stall, flush_mask,
        input  in_ready, out_valid, out_data, occupancy, stage_valid
    );

    modport slave (
        input  in_valid, in_data, out_ready, stall, flush_mask,
        output in_ready, out_valid, out_data, occupancy, stage_valid
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - DEPTH elastic register stages with stall, selective flush and bubble collapse
module pipe_stage_chain #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 3,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input logic                 clk,
    input logic                 reset,
    pipe_stage_chain_if.slave   bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic [DEPTH-1:0]            ev;
    logic [DEPTH-1:0]            adv;
    logic                        acc0;
    logic                        in_fire;

    // Accept ripples from the output end; a scalar carry avoids a self-referencing vector.
    always_comb begin
        logic a;
        ev  = v_q & ~bus.flush_mask;
        adv = '0;
        a   = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = ev[i] & a & ~bus.stall;
            a      = a | ~ev[i];
        end
        acc0    = a;
        in_fire = bus.in_valid & acc0 & ~bus.stall & ~reset;
    end

    // Stall needs no special case: it zeroes adv and in_fire, so only flush acts.
    always_comb begin
        logic             up;
        logic [WIDTH-1:0] up_data;
        v_d     = '0;
        d_d     = d_q;
        occ_d   = '0;
        up      = in_fire;
        up_data = bus.in_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (up) begin
                v_d[i] = 1'b1;
                d_d[i] = up_data;
            end else if (ev[i] && !adv[i]) begin
                v_d[i] = 1'b1;
            end else if (v_q[i] && bus.flush_mask[i] && (CLEAR_ON_FLUSH != 0)) begin
                d_d[i] = '0;
            end
            up      = adv[i];
            up_data = d_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign bus.in_ready    = acc0 & ~bus.stall & ~reset;
    assign bus.out_valid   = ev[DEPTH-1] & ~bus.stall;
    assign bus.out_data    = d_q[DEPTH-1];
    assign bus.occupancy   = occ_q;
    assign bus.stage_valid = v_q;
endmodule
